// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset PC, bubble instruction and primary opcodes.
// The fetch stage and the main decoder both import this package.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INCR = 2'b01,
    PC_LOAD = 2'b10
  } pc_op_e;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: load an aligned target, step by one word, or hold.
// Asynchronous active-low reset returns it to RESET_PC.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_op_e      pc_op,
  input  logic [31:0] load_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_plus4 = pc_q + PC_STEP;
  assign pc       = pc_q;

  // Next-PC selection
  always_comb begin
    pc_d = pc_q;
    case (pc_op)
      PC_LOAD: pc_d = align_word(load_addr);
      PC_INCR: pc_d = pc_plus4;
      PC_HOLD: pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
  end

  // PC state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction-memory request and the IF/ID register.
// Priority each cycle is redirect > stall > memory ready > memory wait (bubble).
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  pc_op_e      pc_op_s;
  logic [31:0] pc_s;
  logic [31:0] pc_plus4_s;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_op     (pc_op_s),
    .load_addr (redirect_target),
    .pc        (pc_s),
    .pc_plus4  (pc_plus4_s)
  );

  assign imem_addr = pc_s;
  assign imem_req  = rst_n & ~stall & ~redirect;

  // Stage control: PC operation and IF/ID next values
  always_comb begin
    pc_op_s       = PC_HOLD;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      // Wrong-path data arriving this cycle is discarded along with the stall.
      pc_op_s      = PC_LOAD;
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'h0000_0000;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      pc_op_s = PC_HOLD;
    end else if (imem_ready) begin
      pc_op_s       = PC_INCR;
      ifid_instr_d  = imem_rdata;
      ifid_pc4_d    = pc_plus4_s;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      pc_op_s      = PC_HOLD;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  // IF/ID pipeline register and fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc4_q    <= 32'h0000_0000;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a combinational instruction memory model.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .fetch_count     (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h8C01_0004;
      32'h0000_0004: return 32'h2022_0001;
      default:       return 32'hC000_0000 ^ addr;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0000_0000;
    imem_ready = 1'b1;
    #12;
    chk("rst_instr", ifid_instr, 32'h0000_0000);
    chk("rst_pc4", ifid_pc4, 32'h0000_0000);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    // Two sequential fetches
    tick();
    chk("f1_instr", ifid_instr, 32'h8C01_0004);
    chk("f1_pc4", ifid_pc4, 32'h0000_0004);
    chk("f1_valid", {31'd0, ifid_valid}, 32'd1);
    tick();
    chk("f2_instr", ifid_instr, 32'h2022_0001);
    chk("f2_pc4", ifid_pc4, 32'h0000_0008);
    chk("f2_count", fetch_count, 32'd2);
    chk("f2_addr", imem_addr, 32'h0000_0008);

    // Stall for three cycles at pc 8
    stall = 1'b1;
    #1;
    chk("st_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_addr", imem_addr, 32'h0000_0008);
      chk("st_instr", ifid_instr, 32'h2022_0001);
      chk("st_count", fetch_count, 32'd2);
      chk("st_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("st_rel_instr", ifid_instr, 32'hC000_0008);
    chk("st_rel_pc4", ifid_pc4, 32'h0000_000C);
    chk("st_rel_count", fetch_count, 32'd3);

    // Redirect together with stall: redirect wins
    redirect = 1'b1;
    redirect_target = 32'h0000_0040;
    stall = 1'b1;
    #1;
    chk("rd_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rd_addr", imem_addr, 32'h0000_0040);
    chk("rd_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rd_instr", ifid_instr, 32'h0000_0000);
    chk("rd_pc4", ifid_pc4, 32'h0000_0000);
    chk("rd_count", fetch_count, 32'd3);
    redirect = 1'b0;
    stall = 1'b0;
    tick();
    chk("rd_fetch_instr", ifid_instr, 32'hC000_0040);
    chk("rd_fetch_pc4", ifid_pc4, 32'h0000_0044);
    chk("rd_fetch_valid", {31'd0, ifid_valid}, 32'd1);

    // Memory wait at pc 0x10
    redirect = 1'b1;
    redirect_target = 32'h0000_0010;
    tick();
    redirect = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wt_valid", {31'd0, ifid_valid}, 32'd0);
      chk("wt_instr", ifid_instr, 32'h0000_0000);
      chk("wt_addr", imem_addr, 32'h0000_0010);
    end
    imem_ready = 1'b1;
    tick();
    chk("wt_pc4", ifid_pc4, 32'h0000_0014);
    chk("wt_instr_ok", ifid_instr, 32'hC000_0010);
    chk("wt_count", fetch_count, 32'd5);

    // Misaligned redirect target
    redirect = 1'b1;
    redirect_target = 32'h0000_0043;
    tick();
    chk("mis_addr", imem_addr, 32'h0000_0040);

    // PC wrap at the top of the address space
    redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc4", ifid_pc4, 32'h0000_0000);
    chk("wrap_instr", ifid_instr, 32'h3FFF_FFFC);
    chk("wrap_count", fetch_count, 32'd6);

    // fetch_count wrap
    imem_ready = 1'b0;
    force dut.fetch_count_d = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_count_d;
    chk("fc_preset", fetch_count, 32'hFFFF_FFFF);
    imem_ready = 1'b1;
    tick();
    chk("fc_wrap", fetch_count, 32'h0000_0000);
    chk("fc_instr", ifid_instr, 32'h8C01_0004);

    // Asynchronous reset between edges at pc 0x24
    redirect = 1'b1;
    redirect_target = 32'h0000_0020;
    tick();
    redirect = 1'b0;
    tick();
    chk("ar_pre_addr", imem_addr, 32'h0000_0024);
    chk("ar_pre_valid", {31'd0, ifid_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_addr", imem_addr, 32'h0000_0000);
    chk("ar_valid", {31'd0, ifid_valid}, 32'd0);
    chk("ar_instr", ifid_instr, 32'h0000_0000);
    chk("ar_pc4", ifid_pc4, 32'h0000_0000);
    chk("ar_count", fetch_count, 32'd0);
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_addr", imem_addr, 32'h0000_0000);
    tick();
    chk("ar_rel_instr", ifid_instr, 32'h8C01_0004);
    chk("ar_rel_pc4", ifid_pc4, 32'h0000_0004);
    chk("ar_rel_count", fetch_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
